measure_sig_freq: RTL and testbench

MEASURE_SIG_FREQ -- requirements
Module: measure_sig_freq

---
 rtl/measure_sig_freq.sv | 104 ++++++++++
 tb/tb_measure_sig_freq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/measure_sig_freq.sv
// Gate-window frequency counter: counts rising edges of sig over CLK_HZ/GATE_DIV clocks, reports Hz.
// Result lands GATE_CYCLES clocks after en is sampled; no backpressure, valid is a one-cycle pulse.
module measure_sig_freq #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int GATE_DIV = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        sig,
  output logic [15:0] freq,
  output logic        valid,
  output logic        overflow,
  output logic        busy
);

  localparam int GATE_CYCLES = CLK_HZ / GATE_DIV;
  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GATE, LATCH} state_t;

  state_t        state, state_nxt;
  logic          sync1, sync2, sig_prev, rise;
  logic [GW-1:0] gate_cnt, gate_cnt_nxt;
  logic [31:0]   edge_cnt, edge_cnt_nxt, edge_inc;
  logic [47:0]   prod;
  logic          load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sig_prev <= 1'b0;
    end else begin
      sync1    <= sig;
      sync2    <= sync1;
      sig_prev <= sync2;
    end
  end

  assign rise     = sync2 & ~sig_prev;
  assign edge_inc = (rise && (edge_cnt != '1)) ? edge_cnt + 32'd1 : edge_cnt;

  always_comb begin
    state_nxt    = state;
    gate_cnt_nxt = gate_cnt;
    edge_cnt_nxt = edge_cnt;
    load         = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_nxt    = GATE;
          gate_cnt_nxt = '0;
          edge_cnt_nxt = '0;
        end
      end
      GATE: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (gate_cnt == GATE_LAST) begin
          // the edge seen in the last gate cycle still belongs to this window
          state_nxt    = LATCH;
          edge_cnt_nxt = edge_inc;
          load         = 1'b1;
        end else begin
          gate_cnt_nxt = gate_cnt + GW'(1);
          edge_cnt_nxt = edge_inc;
        end
      end
      LATCH: begin
        gate_cnt_nxt = '0;
        edge_cnt_nxt = '0;
        state_nxt    = en ? GATE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign prod = {16'd0, edge_cnt_nxt} * 48'(GATE_DIV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gate_cnt <= '0;
      edge_cnt <= '0;
      freq     <= 16'd0;
      overflow <= 1'b0;
      valid    <= 1'b0;
    end else begin
      state    <= state_nxt;
      gate_cnt <= gate_cnt_nxt;
      edge_cnt <= edge_cnt_nxt;
      valid    <= load;
      if (load) begin
        freq     <= (prod > 48'd65535) ? 16'hFFFF : prod[15:0];
        overflow <= (prod > 48'd65535);
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_measure_sig_freq.sv
// Bench for measure_sig_freq: two instances (unsaturated and saturating scale) driven in lockstep,
// checked every cycle against an edge-history reference model.
module tb_measure_sig_freq;

  localparam int DIV_A = 10;
  localparam int DIV_B = 2000;

  logic        clk = 1'b0;
  logic        rst_n, en, sig;
  logic [15:0] freq_a, freq_b;
  logic        valid_a, valid_b, ovf_a, ovf_b, busy_a, busy_b;

  always #5 clk = ~clk;

  measure_sig_freq #(.CLK_HZ(1000), .GATE_DIV(DIV_A)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .sig(sig),
    .freq(freq_a), .valid(valid_a), .overflow(ovf_a), .busy(busy_a)
  );

  measure_sig_freq #(.CLK_HZ(200000), .GATE_DIV(DIV_B)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .sig(sig),
    .freq(freq_b), .valid(valid_b), .overflow(ovf_b), .busy(busy_b)
  );

  typedef struct {
    int mode;   // 0/1 hold, >=2 square period, -1 random per clock, -2 random period
    int nwin;
    int ea;     // expected final freq_a, -1 = model only
    int eb;
    int eob;
  } vec_t;

  vec_t   tbl [9];
  int     nvec = 0, nerr = 0;
  int     cyc = 0;
  int     e0, ph;
  bit     hist [0:16383];
  longint exp_fa = 0, exp_fb = 0;
  bit     exp_oa = 0, exp_ob = 0;

  // sig as seen at each rising edge; zero while reset holds the sampling flops clear
  always @(posedge clk) begin
    if (cyc < 16384) hist[cyc] = rst_n ? sig : 1'b0;
    cyc = cyc + 1;
  end

  function automatic bit hs(int i);
    return (i >= 0 && i < 16384) ? hist[i] : 1'b0;
  endfunction

  // edges credited at clock t are 0->1 transitions of sig sampled at t-3 -> t-2
  function automatic int count_rises(int lo, int hi);
    int n = 0;
    for (int t = lo; t <= hi; t++)
      if (hs(t - 2) && !hs(t - 3)) n++;
    return n;
  endfunction

  function automatic longint sat(longint p);
    return (p > 65535) ? 65535 : p;
  endfunction

  task automatic chk(string name, logic [47:0] act, logic [47:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_out(bit ev, bit eb);
    chk("valid_a", 48'(valid_a), 48'(ev));
    chk("valid_b", 48'(valid_b), 48'(ev));
    chk("busy_a", 48'(busy_a), 48'(eb));
    chk("busy_b", 48'(busy_b), 48'(eb));
    chk("freq_a", 48'(freq_a), 48'(exp_fa));
    chk("freq_b", 48'(freq_b), 48'(exp_fb));
    chk("ovf_a", 48'(ovf_a), 48'(exp_oa));
    chk("ovf_b", 48'(ovf_b), 48'(exp_ob));
  endtask

  task automatic drive(int mode);
    if (mode == 0) sig = 1'b0;
    else if (mode == 1) sig = 1'b1;
    else if (mode < 0) sig = 1'($urandom_range(0, 1));
    else begin
      sig = 1'((ph / (mode / 2)) % 2);
      ph++;
    end
  endtask

  // en already high since clock e0; runs nwin whole windows, ending on a result cycle
  task automatic run(int mode, int nwin, int ea, int eb, int eob);
    int last, rel, n;
    bit ev;
    ph = 0;
    drive(mode);
    for (int i = 0; i < nwin * 101; i++) begin
      @(negedge clk);
      last = cyc - 1;
      rel  = last - e0;
      ev   = (rel >= 100) && (((rel - 100) % 101) == 0);
      if (ev) begin
        n      = count_rises(last - 99, last);
        exp_fa = sat(longint'(n) * DIV_A);
        exp_oa = (longint'(n) * DIV_A) > 65535;
        exp_fb = sat(longint'(n) * DIV_B);
        exp_ob = (longint'(n) * DIV_B) > 65535;
      end
      check_out(ev, 1'b1);
      drive(mode);
    end
    if (ea >= 0) begin
      chk("tbl_freq_a", 48'(freq_a), 48'(ea));
      chk("tbl_freq_b", 48'(freq_b), 48'(eb));
      chk("tbl_ovf_b", 48'(ovf_b), 48'(eob));
    end
  endtask

  task automatic clear_exp();
    exp_fa = 0; exp_fb = 0; exp_oa = 0; exp_ob = 0;
  endtask

  initial begin
    int m;
    tbl[0] = '{10, 3, 100, 20000, 0};
    tbl[1] = '{2,  2, 500, 65535, 1};
    tbl[2] = '{10, 2, 100, 20000, 0};
    tbl[3] = '{0,  2, 0,   0,     0};
    tbl[4] = '{1,  2, 0,   0,     0};
    tbl[5] = '{-1, 3, -1,  -1,    -1};
    tbl[6] = '{-2, 2, -1,  -1,    -1};
    tbl[7] = '{-2, 2, -1,  -1,    -1};
    tbl[8] = '{10, 1, 100, 20000, 0};

    rst_n = 1'b0; en = 1'b0; sig = 1'b0;
    repeat (3) @(negedge clk);
    check_out(1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_out(1'b0, 1'b0);

    en = 1'b1;
    e0 = cyc;
    for (int r = 0; r < 9; r++) begin
      m = (tbl[r].mode == -2) ? 2 * int'($urandom_range(1, 20)) : tbl[r].mode;
      run(m, tbl[r].nwin, tbl[r].ea, tbl[r].eb, tbl[r].eob);
    end

    // drop en while the gate counter reads 50
    sig = 1'b0;
    for (int i = 0; i < 51; i++) begin
      @(negedge clk);
      check_out(1'b0, 1'b1);
    end
    en = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      check_out(1'b0, 1'b0);
    end

    // reset in the middle of a gate
    en = 1'b1;
    e0 = cyc;
    for (int i = 0; i < 52; i++) begin
      @(negedge clk);
      check_out(1'b0, 1'b1);
    end
    rst_n = 1'b0;
    #1;
    clear_exp();
    check_out(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_out(1'b0, 1'b0);
    rst_n = 1'b1;
    e0 = cyc;
    run(10, 2, 100, 20000, 0);

    // sig already high when reset releases counts as one edge
    rst_n = 1'b0;
    sig = 1'b1;
    #1;
    clear_exp();
    check_out(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    e0 = cyc;
    run(1, 1, 10, 2000, 0);

    en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
